prog_sequencer: RTL
===================

# prog_sequencer

Parametrised program sequencer that fetches instructions from an internal program memory and replays them onto the controller's register interface. It sits between the top-level controller and regintf. It adds three things: host loading of the program memory, register reads with captured data, and control instructions (WAIT on one of N done channels, counted LOOP, HALT). It also keeps the existing auto-wait on write-to-WOC and the next_layer pulse.

## Interface
- ADDR_W, 14, register address width (≥8)
- DATA_W, 16, register data width (≥8)
- DEPTH, 1024, program memory depth; PC_W = $clog2(DEPTH), PC_W ≤ ADDR_W
- N_DONE, 2, number of done channels; CH_W = max(1,$clog2(N_DONE))
- LAYER_ADDR, 1, a write to this address pulses next_layer
- Instruction width IW = 2+ADDR_W+DATA_W; fields op=[IW-1:IW-2], addr=[IW-3:DATA_W], data=[DATA_W-1:0]
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prog_we / prog_addr / prog_wdata  in  1 / PC_W / IW  program load port; accepted only in IDLE with run_program=0, ignored otherwise
- run_program  in  1  level; enables fetching
- abort  in  1  synchronous; returns to IDLE with pc=0, loop cleared, halted/err cleared
- pc_max  in  PC_W+1  number of valid instructions
- done_executing  in  N_DONE  per-channel done, level-sampled
- wr_en_drv, rd_en_drv  out  1  regintf strobes, one cycle
- addr_drv  out  ADDR_W; write_data_drv  out  DATA_W
- read_data_drv  in  DATA_W  regintf read data, valid 1 cycle after rd_en_drv
- rd_data_q  out  DATA_W  last captured read; rd_valid  out  1  one-cycle pulse
- execute_2  out  1  pulse on entering WAIT_DONE; next_layer  out  1  pulse
- prog_done  out  1  pulse when pc reaches pc_max; halted, err, busy  out  1  levels
- pc_out  out  PC_W+1  current pc

## Operation
- Opcodes: 00 NOP. 01 WRITE (addr←data). 10 READ (addr). 11 CTRL, with subop=data[DATA_W-1:DATA_W-2]:
  - 00 WAIT, channel=data[CH_W-1:0]
  - 01 LOOP, target=addr[PC_W-1:0], count=data[DATA_W-3:0]
  - 10 HALT
  - 11 illegal
- States:
  - IDLE: if run_program && !halted && pc<pc_max → FETCH. If run_program && pc==pc_max on the cycle of arrival → prog_done pulse once (re-armed by abort or new load).
  - FETCH: memory read of pc issued; → EXEC.
  - EXEC: instr valid. Default pc←pc+1; strobes are driven this cycle only. Next state:
    - WRITE to WOC region (addr[ADDR_W-1:ADDR_W-7]==7'h01) → WAIT_DONE on ch0.
    - READ → RD_CAP.
    - WAIT → WAIT_DONE on the selected channel.
    - HALT → HALTED.
    - Illegal subop, or WAIT channel ≥ N_DONE → err=1, HALTED.
    - Anything else → IDLE.
  - RD_CAP: rd_data_q←read_data_drv, rd_valid=1 next cycle; → IDLE.
  - WAIT_DONE: stays until the selected done bit is 1; → IDLE.
  - HALTED: stays until abort; halted=1.
- LOOP (single level, loop_cnt register DATA_W-2 bits, loop_act flag):
  - !loop_act: count==0 → fall through; else loop_cnt←count-1, loop_act←1, pc←target.
  - loop_act: loop_cnt==0 → loop_act←0, fall through; else loop_cnt←loop_cnt-1, pc←target.
  - Net effect: the body runs count+1 times.
  - If target ≥ pc_max: err=1, HALTED.
- next_layer pulses on the clock after EXEC for WRITE with addr==LAYER_ADDR. It is independent of the wait decision.
- busy = state≠IDLE && state≠HALTED.
- run_program deasserted mid-program: the current instruction completes (including any wait); the block then holds in IDLE with pc retained (pause/resume).
- abort has priority over all state activity, including WAIT_DONE and RD_CAP. Any capture still pending is dropped.

## Timing
- Reset values:
  - state=IDLE, pc=0, loop_act=0, loop_cnt=0
  - all strobes/pulses 0, rd_data_q=0, halted=0, err=0, busy=0, pc_out=0
- Instruction latency:
  - NOP/WRITE/LOOP: 3 cycles (IDLE, FETCH, EXEC).
  - READ: 4 cycles, with rd_valid 1 cycle after RD_CAP.
  - WAIT: 3 cycles + wait.
- wr_en_drv/rd_en_drv/addr_drv/write_data_drv are combinational from the instr register, gated to EXEC.
- WAIT_DONE with done already 1 on entry: exits after exactly one cycle.
- A prog_we arriving in the same cycle as run_program rising: the write is accepted and the fetch starts the next cycle.

## Test plan
- Load [WRITE 0x0010←0xABCD, READ 0x0020], pc_max=2, read_data_drv=0x1234 → one wr_en_drv with addr 0x0010/data 0xABCD, one rd_en_drv at 0x0020, rd_data_q=0x1234 with rd_valid pulse, prog_done once, pc_out=2.
- WRITE to 0x0080 (WOC), done[0] held 0 for 10 cycles then 1 → execute_2 pulse, busy for 10+ cycles, return to IDLE; WRITE to LAYER_ADDR → single next_layer pulse.
- LOOP with target=0, count=3 after a 1-instruction body → body wr_en_drv count 4, loop_act=0 afterwards, pc continues past LOOP.
- WAIT ch=1 with done=2'b01 then 2'b10 → waits until bit1; WAIT ch=3 with N_DONE=2 → err=1, halted=1.
- HALT mid-program → halted, no further strobes despite run_program=1; abort → pc_out=0, halted=0, err=0.
- Async rst asserted in WAIT_DONE and in RD_CAP → all outputs at reset values immediately; prog_we while busy → memory unchanged (verified by re-run).

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: replays instructions from an internal program memory onto the
// register interface, with reads, done-channel waits, a single-level loop and halt.
module prog_sequencer #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 1024,
    parameter int N_DONE     = 2,
    parameter int LAYER_ADDR = 1,
    localparam int PC_W      = $clog2(DEPTH),
    localparam int IW        = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [IW-1:0]     prog_wdata,
    input  logic              run_program,
    input  logic              abort,
    input  logic [PC_W:0]     pc_max,
    input  logic [N_DONE-1:0] done_executing,
    output logic              wr_en_drv,
    output logic              rd_en_drv,
    output logic [ADDR_W-1:0] addr_drv,
    output logic [DATA_W-1:0] write_data_drv,
    input  logic [DATA_W-1:0] read_data_drv,
    output logic [DATA_W-1:0] rd_data_q,
    output logic              rd_valid,
    output logic              execute_2,
    output logic              next_layer,
    output logic              prog_done,
    output logic              halted,
    output logic              err,
    output logic              busy,
    output logic [PC_W:0]     pc_out
);
    localparam int CH_W  = (N_DONE > 1) ? $clog2(N_DONE) : 1;
    localparam int CNT_W = DATA_W - 2;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CTRL  = 2'b11;
    localparam logic [1:0] SUB_WAIT = 2'b00;
    localparam logic [1:0] SUB_LOOP = 2'b01;
    localparam logic [1:0] SUB_HALT = 2'b10;

    localparam logic [PC_W:0]     PC_ONE   = (PC_W+1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  N_DONE_L = CNT_W'(N_DONE);
    localparam logic [ADDR_W-1:0] LAYER_L  = ADDR_W'(LAYER_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_RD_CAP,
        S_WAIT_DONE,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W:0]     pc_q, pc_d;
    logic              loop_act_q, loop_act_d;
    logic [CNT_W-1:0]  loop_cnt_q, loop_cnt_d;
    logic [CH_W-1:0]   wait_ch_q, wait_ch_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;
    logic              done_flag_q, done_flag_d;
    logic              run_prev_q;
    logic              rd_valid_q, rd_valid_d;
    logic              execute_2_q, execute_2_d;
    logic              next_layer_q, next_layer_d;
    logic              prog_done_q, prog_done_d;
    logic [DATA_W-1:0] rd_data_d;

    logic [IW-1:0]     mem [DEPTH];
    logic [IW-1:0]     instr_q;
    logic              prog_accept;

    logic [1:0]        op;
    logic [1:0]        subop;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic [CNT_W-1:0]  i_cnt;
    logic [PC_W:0]     target;
    logic              in_exec;

    assign op      = instr_q[IW-1:IW-2];
    assign i_addr  = instr_q[IW-3:DATA_W];
    assign i_data  = instr_q[DATA_W-1:0];
    assign subop   = i_data[DATA_W-1:DATA_W-2];
    assign i_cnt   = i_data[CNT_W-1:0];
    assign target  = {1'b0, i_addr[PC_W-1:0]};
    assign in_exec = (state_q == S_EXEC);

    // A load coinciding with run_program rising is still accepted, hence run_prev_q.
    assign prog_accept = prog_we && (state_q == S_IDLE) && (!run_program || !run_prev_q);

    always_ff @(posedge clk) begin
        if (prog_accept) mem[prog_addr] <= prog_wdata;
        if (state_q == S_FETCH) instr_q <= mem[pc_q[PC_W-1:0]];
    end

    assign wr_en_drv      = in_exec && (op == OP_WRITE);
    assign rd_en_drv      = in_exec && (op == OP_READ);
    assign addr_drv       = in_exec ? i_addr : '0;
    assign write_data_drv = in_exec ? i_data : '0;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        loop_act_d   = loop_act_q;
        loop_cnt_d   = loop_cnt_q;
        wait_ch_d    = wait_ch_q;
        err_d        = err_q;
        done_flag_d  = done_flag_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        next_layer_d = 1'b0;
        prog_done_d  = 1'b0;

        if (prog_accept) done_flag_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_program) begin
                    if (pc_q < pc_max) begin
                        state_d = S_FETCH;
                    end else if (!done_flag_q) begin
                        prog_done_d = 1'b1;
                        done_flag_d = 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                pc_d    = pc_q + PC_ONE;
                state_d = S_IDLE;
                case (op)
                    OP_WRITE: begin
                        next_layer_d = (i_addr == LAYER_L);
                        if (i_addr[ADDR_W-1:ADDR_W-7] == 7'h01) begin
                            wait_ch_d = '0;
                            state_d   = S_WAIT_DONE;
                        end
                    end
                    OP_READ: state_d = S_RD_CAP;
                    OP_CTRL: begin
                        case (subop)
                            SUB_WAIT: begin
                                // The whole field is range-checked so stray high bits cannot alias a real channel.
                                if (i_cnt >= N_DONE_L) begin
                                    err_d   = 1'b1;
                                    state_d = S_HALTED;
                                end else begin
                                    wait_ch_d = i_data[CH_W-1:0];
                                    state_d   = S_WAIT_DONE;
                                end
                            end
                            SUB_LOOP: begin
                                if (target >= pc_max) begin
                                    err_d   = 1'b1;
                                    state_d = S_HALTED;
                                end else if (!loop_act_q) begin
                                    if (i_cnt != '0) begin
                                        loop_cnt_d = i_cnt - CNT_ONE;
                                        loop_act_d = 1'b1;
                                        pc_d       = target;
                                    end
                                end else if (loop_cnt_q == '0) begin
                                    loop_act_d = 1'b0;
                                end else begin
                                    loop_cnt_d = loop_cnt_q - CNT_ONE;
                                    pc_d       = target;
                                end
                            end
                            SUB_HALT: state_d = S_HALTED;
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_HALTED;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            S_RD_CAP: begin
                rd_data_d  = read_data_drv;
                rd_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (done_executing[wait_ch_q]) state_d = S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a capture still in flight.
        if (abort) begin
            state_d      = S_IDLE;
            pc_d         = '0;
            loop_act_d   = 1'b0;
            loop_cnt_d   = '0;
            err_d        = 1'b0;
            done_flag_d  = 1'b0;
            rd_data_d    = rd_data_q;
            rd_valid_d   = 1'b0;
            next_layer_d = 1'b0;
            prog_done_d  = 1'b0;
        end

        execute_2_d = (state_d == S_WAIT_DONE) && (state_q != S_WAIT_DONE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_HALTED);
        halted_d    = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            loop_act_q   <= 1'b0;
            loop_cnt_q   <= '0;
            wait_ch_q    <= '0;
            err_q        <= 1'b0;
            halted_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_flag_q  <= 1'b0;
            run_prev_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            execute_2_q  <= 1'b0;
            next_layer_q <= 1'b0;
            prog_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            loop_act_q   <= loop_act_d;
            loop_cnt_q   <= loop_cnt_d;
            wait_ch_q    <= wait_ch_d;
            err_q        <= err_d;
            halted_q     <= halted_d;
            busy_q       <= busy_d;
            done_flag_q  <= done_flag_d;
            run_prev_q   <= run_program;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            execute_2_q  <= execute_2_d;
            next_layer_q <= next_layer_d;
            prog_done_q  <= prog_done_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign execute_2  = execute_2_q;
    assign next_layer = next_layer_q;
    assign prog_done  = prog_done_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign pc_out     = pc_q;
endmodule
